// File: rtl/riscv_signature_pkg.sv
// Shared types and header field layout for the riscv-dv style signature decoder.
package riscv_signature_pkg;

    typedef enum logic [7:0] {
        CORE_STATUS = 8'd0,
        TEST_RESULT = 8'd1,
        WRITE_GPR   = 8'd2,
        WRITE_CSR   = 8'd3
    } signature_type_t;

    typedef enum logic [4:0] {
        INITIALIZED           = 5'd0,
        IN_DEBUG_MODE         = 5'd1,
        IN_MACHINE_MODE       = 5'd2,
        IN_HYPERVISOR_MODE    = 5'd3,
        IN_SUPERVISOR_MODE    = 5'd4,
        IN_USER_MODE          = 5'd5,
        HANDLING_IRQ          = 5'd6,
        FINISHED_IRQ          = 5'd7,
        HANDLING_EXCEPTION    = 5'd8,
        INSTR_FAULT_EXCEPTION = 5'd9
    } core_status_t;

    typedef enum logic {
        TEST_PASS = 1'b0,
        TEST_FAIL = 1'b1
    } test_result_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GPR_DATA = 2'd1,
        CSR_DATA = 2'd2
    } sig_decoder_state_t;

    localparam int unsigned NUM_GPR    = 32;
    localparam int unsigned GPR_IDX_W  = $clog2(NUM_GPR);

    localparam int unsigned TYPE_LSB     = 0;
    localparam int unsigned TYPE_W       = 8;
    localparam int unsigned STATUS_LSB   = 8;
    localparam int unsigned STATUS_W     = 5;
    localparam int unsigned RESULT_BIT   = 8;
    localparam int unsigned CSR_ADDR_LSB = 8;
    localparam int unsigned CSR_ADDR_W   = 12;

endpackage

// File: rtl/riscv_signature_decoder.sv
// Decodes the riscv-dv signature store stream into status, result, GPR dump and CSR events.
module riscv_signature_decoder
    import riscv_signature_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter logic [31:0] SIGNATURE_ADDR = 32'h8FFF_FFF8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [31:0]             wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    output logic                    status_valid,
    output logic [STATUS_W-1:0]     status,
    output logic                    test_done,
    output logic                    test_fail,
    output logic                    gpr_valid,
    output logic [GPR_IDX_W-1:0]    gpr_idx,
    output logic [XLEN-1:0]         gpr_data,
    output logic                    gpr_dump_done,
    output logic                    csr_valid,
    output logic [CSR_ADDR_W-1:0]   csr_addr,
    output logic [XLEN-1:0]         csr_data,
    output logic                    protocol_err,
    output logic                    busy
);

    sig_decoder_state_t     state_q, state_d;
    logic [GPR_IDX_W-1:0]   cnt_q, cnt_d;
    logic                   status_valid_q, status_valid_d;
    logic [STATUS_W-1:0]    status_q, status_d;
    logic                   test_done_q, test_done_d;
    logic                   test_fail_q, test_fail_d;
    logic                   gpr_valid_q, gpr_valid_d;
    logic [GPR_IDX_W-1:0]   gpr_idx_q, gpr_idx_d;
    logic [XLEN-1:0]        gpr_data_q, gpr_data_d;
    logic                   gpr_dump_done_q, gpr_dump_done_d;
    logic                   csr_valid_q, csr_valid_d;
    logic [CSR_ADDR_W-1:0]  csr_addr_q, csr_addr_d;
    logic [XLEN-1:0]        csr_data_q, csr_data_d;
    logic                   protocol_err_q, protocol_err_d;

    logic                   accept;
    logic [TYPE_W-1:0]      hdr_type;
    logic [STATUS_W-1:0]    hdr_status;

    assign accept     = wr_en && (wr_addr == SIGNATURE_ADDR);
    assign hdr_type   = wr_data[TYPE_LSB +: TYPE_W];
    assign hdr_status = wr_data[STATUS_LSB +: STATUS_W];

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        status_valid_d  = 1'b0;
        status_d        = status_q;
        test_done_d     = test_done_q;
        test_fail_d     = test_fail_q;
        gpr_valid_d     = 1'b0;
        gpr_idx_d       = gpr_idx_q;
        gpr_data_d      = gpr_data_q;
        gpr_dump_done_d = 1'b0;
        csr_valid_d     = 1'b0;
        csr_addr_d      = csr_addr_q;
        csr_data_d      = csr_data_q;
        protocol_err_d  = 1'b0;

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    case (hdr_type)
                        CORE_STATUS: begin
                            if (hdr_status <= INSTR_FAULT_EXCEPTION) begin
                                status_valid_d = 1'b1;
                                status_d       = hdr_status;
                            end else begin
                                protocol_err_d = 1'b1;
                            end
                        end
                        TEST_RESULT: begin
                            // Only the first result counts; a repeat is a protocol error.
                            if (test_done_q) begin
                                protocol_err_d = 1'b1;
                            end else begin
                                test_done_d = 1'b1;
                                test_fail_d = wr_data[RESULT_BIT];
                            end
                        end
                        WRITE_GPR: begin
                            cnt_d   = '0;
                            state_d = GPR_DATA;
                        end
                        WRITE_CSR: begin
                            csr_addr_d = wr_data[CSR_ADDR_LSB +: CSR_ADDR_W];
                            state_d    = CSR_DATA;
                        end
                        default: protocol_err_d = 1'b1;
                    endcase
                end
                GPR_DATA: begin
                    gpr_valid_d = 1'b1;
                    gpr_idx_d   = cnt_q;
                    gpr_data_d  = wr_data;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == GPR_IDX_W'(NUM_GPR - 1)) begin
                        gpr_dump_done_d = 1'b1;
                        state_d         = IDLE;
                    end
                end
                CSR_DATA: begin
                    csr_valid_d = 1'b1;
                    csr_data_d  = wr_data;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            status_valid_q  <= 1'b0;
            status_q        <= '0;
            test_done_q     <= 1'b0;
            test_fail_q     <= 1'b0;
            gpr_valid_q     <= 1'b0;
            gpr_idx_q       <= '0;
            gpr_data_q      <= '0;
            gpr_dump_done_q <= 1'b0;
            csr_valid_q     <= 1'b0;
            csr_addr_q      <= '0;
            csr_data_q      <= '0;
            protocol_err_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            status_valid_q  <= status_valid_d;
            status_q        <= status_d;
            test_done_q     <= test_done_d;
            test_fail_q     <= test_fail_d;
            gpr_valid_q     <= gpr_valid_d;
            gpr_idx_q       <= gpr_idx_d;
            gpr_data_q      <= gpr_data_d;
            gpr_dump_done_q <= gpr_dump_done_d;
            csr_valid_q     <= csr_valid_d;
            csr_addr_q      <= csr_addr_d;
            csr_data_q      <= csr_data_d;
            protocol_err_q  <= protocol_err_d;
        end
    end

    assign status_valid  = status_valid_q;
    assign status        = status_q;
    assign test_done     = test_done_q;
    assign test_fail     = test_fail_q;
    assign gpr_valid     = gpr_valid_q;
    assign gpr_idx       = gpr_idx_q;
    assign gpr_data      = gpr_data_q;
    assign gpr_dump_done = gpr_dump_done_q;
    assign csr_valid     = csr_valid_q;
    assign csr_addr      = csr_addr_q;
    assign csr_data      = csr_data_q;
    assign protocol_err  = protocol_err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/riscv_signature_decoder.md
RISCV_SIGNATURE_DECODER -- requirements
Module: riscv_signature_decoder

Interface
REQ-001 Parameter XLEN, default 32: width of the signature bus data word.
REQ-002 Parameter SIGNATURE_ADDR, default 32'h8FFF_FFF8: byte address of the signature location.
REQ-003 clk  input  1  sole clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_en  input  1  core store strobe, one write per cycle when high.
REQ-006 wr_addr  input  32  store byte address.
REQ-007 wr_data  input  XLEN  store data.
REQ-008 status_valid  output  1  one-cycle pulse: core status decoded.
REQ-009 status  output  5  core_status_t value, held until the next status_valid.
REQ-010 test_done  output  1  sticky: TEST_RESULT received.
REQ-011 test_fail  output  1  sticky: the received result was TEST_FAIL.
REQ-012 gpr_valid  output  1  one-cycle pulse: GPR value delivered.
REQ-013 gpr_idx  output  5  register index for gpr_valid.
REQ-014 gpr_data  output  XLEN  register value for gpr_valid.
REQ-015 gpr_dump_done  output  1  one-cycle pulse, coincident with gpr_idx=31.
REQ-016 csr_valid  output  1  one-cycle pulse: CSR value delivered.
REQ-017 csr_addr  output  12  CSR address.
REQ-018 csr_data  output  XLEN  CSR value.
REQ-019 protocol_err  output  1  one-cycle pulse: malformed signature word.
REQ-020 busy  output  1  high while the state is not IDLE.

Function
REQ-021 A write is accepted only when wr_en=1 and wr_addr==SIGNATURE_ADDR; all other writes have no effect.
REQ-022 FSM states are IDLE, GPR_DATA and CSR_DATA.
REQ-023 In IDLE, the decoder treats an accepted write as a header and uses type = wr_data[7:0].
REQ-024 CORE_STATUS header: if wr_data[12:8] <= 9, the decoder pulses status_valid and loads status; otherwise it pulses protocol_err and leaves status unchanged; the state stays IDLE.
REQ-025 TEST_RESULT header: the decoder sets test_done and sets test_fail = wr_data[8]; a second TEST_RESULT pulses protocol_err and leaves both flags unchanged.
REQ-026 WRITE_GPR header: the decoder clears the 5-bit GPR counter and moves to GPR_DATA.
REQ-027 WRITE_CSR header: the decoder captures csr_addr = wr_data[19:8] and moves to CSR_DATA.
REQ-028 An unknown type (>3) pulses protocol_err, and the state stays IDLE.
REQ-029 In GPR_DATA, each accepted write is treated as raw data: the decoder pulses gpr_valid with gpr_idx = counter and gpr_data = wr_data, then increments the counter; the low byte is not interpreted.
REQ-030 On the 32nd GPR write (counter=31), the decoder also pulses gpr_dump_done, wraps the counter to 0, and returns to IDLE.
REQ-031 In CSR_DATA, the next accepted write pulses csr_valid with csr_data = wr_data and returns to IDLE.
REQ-032 All outputs are registered, with one cycle of latency from the accepted write to the pulse; back-to-back writes on consecutive cycles are fully supported with no stall.
REQ-033 The x0 value is forwarded exactly as written; there is no forcing to zero.
REQ-034 test_done and test_fail persist across all later traffic until reset.

Reset
REQ-035 On rst=1 at a clock edge, the state goes to IDLE and the counter to 0.
REQ-036 On the same edge, all pulses, status, test_done, test_fail, gpr_idx, gpr_data, csr_addr, csr_data and busy go to 0.
REQ-037 Reset during GPR_DATA or CSR_DATA abandons the transfer without a pulse, and the next accepted write is decoded as a header.
REQ-038 A write coincident with rst=1 is ignored.

Structure
REQ-039 signature_type_t, core_status_t, test_result_t, a new sig_decoder_state_t enum, NUM_GPR=32 and the header bit-field positions reside in riscv_signature_pkg.
REQ-040 The block is a single module with no sub-module.

Verification
REQ-041 Write 32'h0000_0200 (CORE_STATUS, IN_MACHINE_MODE) -> status_valid for 1 cycle one cycle later, with status=2.
REQ-042 Write WRITE_GPR header then 32 words 0x100+i -> 32 gpr_valid pulses with idx 0..31 and data 0x100..0x11F, gpr_dump_done with idx 31, then busy=0.
REQ-043 Write 32'h0003_4103 (WRITE_CSR, addr 0x341) then 32'hDEAD_BEEF -> csr_valid with csr_addr=0x341 and csr_data=32'hDEAD_BEEF.
REQ-044 Write 32'h0000_0101 (TEST_RESULT, FAIL) then 32'h0000_0001 -> test_done=1 and test_fail=1 after the first write, protocol_err on the second, flags unchanged.
REQ-045 Write 32'h0000_0F00 (status 15) and 32'h0000_0007 (type 7) -> protocol_err on each; then reset after 10 GPR words, followed by a CORE_STATUS header -> the header is decoded as status with no gpr_valid.
